// File: rtl/registros_arbiter_ctrl.sv
// Round-robin arbiter and fill controller for the Registro shift-register bank.
// Two requesters compete for the bank. Each granted word is delivered as a
// one-cycle push pulse. Once DEPTH words are loaded the bank is frozen until
// the consumer acknowledges the frame.
//
// Handshake: a requester raises req and holds req/data until it sees its gnt
// (combinational, same cycle). The word is then accepted on that rising edge.
// Dropping req before a grant is allowed and leaves no trace.
module registros_arbiter_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_a_i,
    input  logic [WIDTH-1:0] data_a_i,
    output logic             gnt_a_o,
    input  logic             req_b_i,
    input  logic [WIDTH-1:0] data_b_i,
    output logic             gnt_b_o,
    output logic             push_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic [DEPTH-1:0] owner_o,
    input  logic             frame_ack_i,
    output logic             state_o
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state, state_nxt;

    // prio_b names who wins the next tie: 0 = A, 1 = B. It always points at
    // the requester that was not granted last, so after reset A wins.
    logic prio_b;
    logic grant;
    logic last_word;

    assign full_o    = (state == FULL);
    assign state_o   = (state == FULL);
    assign grant     = gnt_a_o | gnt_b_o;
    assign last_word = (count_o == CNT_W'(DEPTH - 1));

    // Arbitration: grants only while filling and not in reset
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (state == FILL && !rst_i) begin
            if (req_a_i && req_b_i) begin
                if (prio_b) gnt_b_o = 1'b1;
                else        gnt_a_o = 1'b1;
            end else if (req_a_i) begin
                gnt_a_o = 1'b1;
            end else if (req_b_i) begin
                gnt_b_o = 1'b1;
            end
        end
    end

    // Next state: the grant that completes the frame freezes the bank,
    // the consumer's ack releases it; ack while filling is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (grant && last_word) state_nxt = FULL;
            FULL: if (frame_ack_i)        state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= FILL;
        else       state <= state_nxt;
    end

    // Datapath: push pulse, word, fill count, ownership history, rr pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            push_o  <= 1'b0;
            data_o  <= '0;
            count_o <= '0;
            owner_o <= '0;
            prio_b  <= 1'b0;
        end else if (grant) begin
            push_o  <= 1'b1;
            data_o  <= gnt_b_o ? data_b_i : data_a_i;
            count_o <= count_o + CNT_W'(1);
            owner_o <= {owner_o[DEPTH-2:0], gnt_b_o};
            prio_b  <= gnt_a_o;
        end else begin
            push_o <= 1'b0;
            if (state == FULL && frame_ack_i) count_o <= '0;
        end
    end

endmodule

// File: tb/tb_registros_arbiter_ctrl.sv
// Bench for registros_arbiter_ctrl: directed scenarios followed by a random
// phase, all compared cycle by cycle against a transaction-level model.
module tb_registros_arbiter_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i = 1'b1;
    logic             req_a_i = 1'b0, req_b_i = 1'b0, frame_ack_i = 1'b0;
    logic [WIDTH-1:0] data_a_i = '0, data_b_i = '0;
    logic             gnt_a_o, gnt_b_o, push_o, full_o, state_o;
    logic [WIDTH-1:0] data_o;
    logic [CNT_W-1:0] count_o;
    logic [DEPTH-1:0] owner_o;

    registros_arbiter_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_a_i(req_a_i), .data_a_i(data_a_i), .gnt_a_o(gnt_a_o),
        .req_b_i(req_b_i), .data_b_i(data_b_i), .gnt_b_o(gnt_b_o),
        .push_o(push_o), .data_o(data_o), .count_o(count_o), .full_o(full_o),
        .owner_o(owner_o), .frame_ack_i(frame_ack_i), .state_o(state_o)
    );

    // reference model: words loaded, frame-full flag, last pushed word,
    // list of sources (newest first), and who was granted last (0 none, 1 A, 2 B)
    int               m_count = 0;
    bit               m_full = 0;
    bit               m_push = 0;
    logic [WIDTH-1:0] m_data = '0;
    bit               owner_q[$];
    int               m_last = 0;

    int n_pass = 0;
    int n_total = 0;
    bit ga, gb;

    function automatic logic [DEPTH-1:0] model_owner();
        logic [DEPTH-1:0] o = '0;
        for (int i = 0; i < owner_q.size(); i++) o[i] = owner_q[i];
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: apply ack/rst, check at the falling edge, advance model
    task automatic cycle(input bit ack, input bit rst, output bit ea, output bit eb);
        frame_ack_i = ack;
        rst_i       = rst;
        @(negedge clk);
        ea = 0;
        eb = 0;
        if (!rst && !m_full) begin
            if (req_a_i && req_b_i) begin
                if (m_last == 1) eb = 1;
                else             ea = 1;
            end else if (req_a_i) ea = 1;
            else if (req_b_i)     eb = 1;
        end
        check("gnt_a", 64'(gnt_a_o), 64'(ea));
        check("gnt_b", 64'(gnt_b_o), 64'(eb));
        check("push", 64'(push_o), 64'(m_push));
        check("data", 64'(data_o), 64'(m_data));
        check("count", 64'(count_o), 64'(m_count));
        check("full", 64'(full_o), 64'(m_full));
        check("state", 64'(state_o), 64'(m_full));
        check("owner", 64'(owner_o), 64'(model_owner()));
        @(posedge clk);
        #1;
        if (rst) begin
            m_count = 0; m_full = 0; m_push = 0; m_data = '0; m_last = 0;
            owner_q.delete();
        end else if (ea || eb) begin
            m_push = 1;
            m_data = ea ? data_a_i : data_b_i;
            m_count++;
            owner_q.push_front(eb);
            if (owner_q.size() > DEPTH) void'(owner_q.pop_back());
            m_last = ea ? 1 : 2;
            if (m_count == DEPTH) m_full = 1;
        end else begin
            m_push = 0;
            if (m_full && ack) begin
                m_full  = 0;
                m_count = 0;
            end
        end
    endtask

    task automatic idle(input int n, input bit ack);
        bit a, b;
        for (int i = 0; i < n; i++) cycle(ack, 0, a, b);
    endtask

    initial begin
        // 1: reset with both requests high
        req_a_i = 1; req_b_i = 1;
        cycle(0, 1, ga, gb);
        cycle(0, 1, ga, gb);
        req_b_i = 0;

        // 2: A alone, 0x11..0x44
        for (int n = 1; n <= 4; n++) begin
            data_a_i = WIDTH'(n * 'h11);
            cycle(0, 0, ga, gb);
        end
        req_a_i = 0;
        idle(1, 0);
        check("t2_owner", 64'(owner_o), 64'(4'b0000));
        idle(1, 1);

        // 3: contention from reset
        req_a_i = 1; req_b_i = 1;
        cycle(0, 1, ga, gb);
        data_a_i = 32'hA0; data_b_i = 32'hB0;
        for (int n = 0; n < 4; n++) begin
            cycle(0, 0, ga, gb);
            if (ga) data_a_i++;
            if (gb) data_b_i++;
        end
        check("t3_owner", 64'(owner_o), 64'(4'b0101));

        // 4: hold while full, then ack; A (not granted last) wins next
        idle(5, 0);
        idle(1, 1);
        for (int n = 0; n < 4; n++) begin
            cycle(0, 0, ga, gb);
            if (ga) data_a_i++;
            if (gb) data_b_i++;
        end
        req_b_i = 0;
        idle(1, 1);

        // 5: stray ack while filling at count 2
        data_a_i = 32'h55;
        idle(2, 0);
        idle(1, 1);
        idle(3, 0);
        req_a_i = 0;
        idle(1, 1);

        // 6: reset in a grant cycle at count 3, then A wins the first tie
        req_a_i = 1; req_b_i = 1;
        idle(3, 0);
        cycle(0, 1, ga, gb);
        idle(2, 0);

        // random phase
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0), ga, gb);
            if (ga || !req_a_i || $urandom_range(0, 7) == 0) begin
                req_a_i  = 1'($urandom_range(0, 1));
                data_a_i = $urandom;
            end
            if (gb || !req_b_i || $urandom_range(0, 7) == 0) begin
                req_b_i  = 1'($urandom_range(0, 1));
                data_b_i = $urandom;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
